// File: rtl/vend_ctrl_mc.sv
// ---------------------------------------------------------------------------
// vend_ctrl_mc
// Vending controller with three coin channels, an internal credit
// accumulator and internal cycle timers. Sequences IDLE -> COIN -> VEND ->
// REFUND and pays change back one CHANGE_UNIT pulse at a time.
//
// Ports
//   clk            in   clock
//   rst            in   asynchronous, active-high reset
//   coin_i[2:0]    in   per-channel coin-accepted pulses (1 cycle each)
//   buy_i          in   purchase request pulse
//   withdraw_i     in   refund request pulse
//   price_i        in   product price, sampled when buy_i is accepted
//   credit_o       out  current credit
//   state_o[1:0]   out  0 IDLE, 1 COIN, 2 VEND, 3 REFUND
//   dispense_o     out  product dispense strobe (VEND_CYC cycles)
//   change_o       out  change-hopper pulse, one CHANGE_UNIT each
//   coin_reject_o  out  1-cycle pulse: coin blocked or would overflow
//   short_o        out  1-cycle pulse: buy rejected for insufficient credit
//
// Optional build macro VEND_AUDIT_EN adds:
//   vend_cnt_o[15:0]          accepted purchases, wrapping
//   revenue_o[CREDIT_W+15:0]  sum of accepted prices, wrapping
//
// All outputs come straight from flops. Timer parameters larger than
// 2^TMR_W-1 (or smaller than 1) stop elaboration.
// ---------------------------------------------------------------------------
module vend_ctrl_mc #(
   parameter int CREDIT_W    = 8,
   parameter int COIN0_VAL   = 1,
   parameter int COIN1_VAL   = 2,
   parameter int COIN2_VAL   = 5,
   parameter int CHANGE_UNIT = 1,
   parameter int TMR_W       = 16,
   parameter int VEND_CYC    = 8,
   parameter int CHANGE_CYC  = 4,
   parameter int TIMEOUT_CYC = 100
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          coin_i,
   input  logic                buy_i,
   input  logic                withdraw_i,
   input  logic [CREDIT_W-1:0] price_i,
   output logic [CREDIT_W-1:0] credit_o,
   output logic [1:0]          state_o,
   output logic                dispense_o,
   output logic                change_o,
   output logic                coin_reject_o,
   output logic                short_o
`ifdef VEND_AUDIT_EN
   ,
   output logic [15:0]         vend_cnt_o,
   output logic [CREDIT_W+15:0] revenue_o
`endif
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_COIN   = 2'd1;
   localparam logic [1:0] ST_VEND   = 2'd2;
   localparam logic [1:0] ST_REFUND = 2'd3;

   localparam longint      TMR_MAX    = (longint'(1) << TMR_W) - 1;
   localparam logic [31:0] CREDIT_MAX = 32'((64'd1 << CREDIT_W) - 64'd1);

   // Terminal timer values: a state is left on the edge that ends the cycle
   // in which the timer holds its *_LAST value.
   localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0] VEND_LAST = TMR_W'(VEND_CYC - 1);
   localparam logic [TMR_W-1:0] CHG_LAST  = TMR_W'(CHANGE_CYC - 1);

   localparam logic [CREDIT_W-1:0] CHG_UNIT = CREDIT_W'(CHANGE_UNIT);

   generate
      if (TIMEOUT_CYC < 1 || VEND_CYC < 1 || CHANGE_CYC < 1 ||
          longint'(TIMEOUT_CYC) > TMR_MAX || longint'(VEND_CYC) > TMR_MAX ||
          longint'(CHANGE_CYC) > TMR_MAX) begin : g_cfg_err
         $error("vend_ctrl_mc: timer parameter out of range for TMR_W");
      end
   endgenerate

   // Credit value of one cycle's coin pulses; several channels may fire at once.
   function automatic logic [31:0] coin_value(input logic [2:0] c);
      logic [31:0] s;
      s = '0;
      if (c[0]) s = s + 32'(COIN0_VAL);
      if (c[1]) s = s + 32'(COIN1_VAL);
      if (c[2]) s = s + 32'(COIN2_VAL);
      return s;
   endfunction

   // One change pulse removes min(CHANGE_UNIT, credit), never wrapping below 0.
   function automatic logic [CREDIT_W-1:0] change_deduct(input logic [CREDIT_W-1:0] c);
      if (c < CHG_UNIT) return '0;
      else              return c - CHG_UNIT;
   endfunction

   logic [1:0]          state_q,   state_d;
   logic [CREDIT_W-1:0] credit_q,  credit_d;
   logic [TMR_W-1:0]    tmr_q,     tmr_d;
   logic                dispense_q, dispense_d;
   logic                change_q,   change_d;
   logic                reject_q,   reject_d;
   logic                short_q,    short_d;

   logic                coin_any;
   logic [31:0]         coin_sum;
   logic [31:0]         credit_sum;
   logic                coin_ovf;
   logic                coin_ok;
   logic [CREDIT_W-1:0] credit_coin;

   // Coin arithmetic is done in 32 bits so overflow past the credit width is
   // visible; an overflowing cycle rejects every coin in it.
   always_comb begin
      coin_any    = |coin_i;
      coin_sum    = coin_value(coin_i);
      credit_sum  = 32'(credit_q) + coin_sum;
      coin_ovf    = credit_sum > CREDIT_MAX;
      coin_ok     = coin_any && !coin_ovf;
      credit_coin = coin_ok ? credit_sum[CREDIT_W-1:0] : credit_q;
   end

   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      tmr_d      = tmr_q;
      dispense_d = 1'b0;
      change_d   = 1'b0;
      reject_d   = 1'b0;
      short_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Buttons are ignored here; only a coin starts a session.
            tmr_d = '0;
            if (coin_ok) begin
               credit_d = credit_coin;
               state_d  = ST_COIN;
            end else if (coin_any) begin
               reject_d = 1'b1;
            end
         end

         ST_COIN: begin
            // Coins in this cycle are credited before the price comparison.
            credit_d = credit_coin;
            reject_d = coin_any && coin_ovf;
            if (withdraw_i) begin
               state_d = ST_REFUND;
               tmr_d   = '0;
            end else if (buy_i) begin
               tmr_d = '0;
               if (credit_coin >= price_i) begin
                  credit_d   = credit_coin - price_i;
                  state_d    = ST_VEND;
                  dispense_d = 1'b1;
               end else begin
                  short_d = 1'b1;
               end
            end else if (coin_any) begin
               tmr_d = '0;
            end else if (tmr_q == TO_LAST) begin
               state_d = ST_REFUND;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         ST_VEND: begin
            // Strobe was raised on the entry edge; hold it for VEND_CYC cycles.
            reject_d = coin_any;
            if (tmr_q == VEND_LAST) begin
               tmr_d   = '0;
               state_d = (credit_q == '0) ? ST_IDLE : ST_REFUND;
            end else begin
               tmr_d      = tmr_q + TMR_W'(1);
               dispense_d = 1'b1;
            end
         end

         ST_REFUND: begin
            // Zero credit (on entry or after the last pulse) exits next edge.
            reject_d = coin_any;
            if (credit_q == '0) begin
               state_d = ST_IDLE;
               tmr_d   = '0;
            end else if (tmr_q == CHG_LAST) begin
               change_d = 1'b1;
               credit_d = change_deduct(credit_q);
               tmr_d    = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            tmr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         credit_q   <= '0;
         tmr_q      <= '0;
         dispense_q <= 1'b0;
         change_q   <= 1'b0;
         reject_q   <= 1'b0;
         short_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         tmr_q      <= tmr_d;
         dispense_q <= dispense_d;
         change_q   <= change_d;
         reject_q   <= reject_d;
         short_q    <= short_d;
      end
   end

   assign credit_o      = credit_q;
   assign state_o       = state_q;
   assign dispense_o    = dispense_q;
   assign change_o      = change_q;
   assign coin_reject_o = reject_q;
   assign short_o       = short_q;

`ifdef VEND_AUDIT_EN
   logic [15:0]          vend_cnt_q;
   logic [CREDIT_W+15:0] revenue_q;
   logic                 buy_ok;

   // Same acceptance condition as the COIN-state buy branch above.
   assign buy_ok = (state_q == ST_COIN) && !withdraw_i && buy_i &&
                   (credit_coin >= price_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vend_cnt_q <= '0;
         revenue_q  <= '0;
      end else if (buy_ok) begin
         vend_cnt_q <= vend_cnt_q + 16'd1;
         revenue_q  <= revenue_q + {16'd0, price_i};
      end
   end

   assign vend_cnt_o = vend_cnt_q;
   assign revenue_o  = revenue_q;
`endif

endmodule

// File: tb/tb_vend_ctrl_mc.sv
module tb_vend_ctrl_mc;

   logic       clk;
   logic       rst;
   logic [2:0] coin_i;
   logic       buy_i;
   logic       withdraw_i;
   logic [7:0] price_i;
   logic [7:0] credit_o;
   logic [1:0] state_o;
   logic       dispense_o;
   logic       change_o;
   logic       coin_reject_o;
   logic       short_o;
`ifdef VEND_AUDIT_EN
   logic [15:0] vend_cnt_o;
   logic [23:0] revenue_o;
`endif

   int errors = 0;
   int checks = 0;

   vend_ctrl_mc dut (
      .clk          (clk),
      .rst          (rst),
      .coin_i       (coin_i),
      .buy_i        (buy_i),
      .withdraw_i   (withdraw_i),
      .price_i      (price_i),
      .credit_o     (credit_o),
      .state_o      (state_o),
      .dispense_o   (dispense_o),
      .change_o     (change_o),
      .coin_reject_o(coin_reject_o),
      .short_o      (short_o)
`ifdef VEND_AUDIT_EN
      ,
      .vend_cnt_o   (vend_cnt_o),
      .revenue_o    (revenue_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one active edge and settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic coin(input logic [2:0] c);
      coin_i = c;
      tick();
      coin_i = 3'b000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ticks(2);
      rst = 1'b0;
      tick();
   endtask

   // Runs until IDLE (bounded), counting change and dispense pulses.
   task automatic drain(output int nchg, output int ndisp, output int ok);
      nchg  = 0;
      ndisp = 0;
      ok    = 0;
      for (int i = 0; i < 200; i++) begin
         if (state_o == 2'd0) begin
            ok = 1;
            break;
         end
         nchg  += int'(change_o);
         ndisp += int'(dispense_o);
         tick();
      end
   endtask

   int nchg, ndisp, ok;

   initial begin
      rst = 1'b1; coin_i = '0; buy_i = 0; withdraw_i = 0; price_i = '0;
      ticks(2);
      chk("rst_state",    state_o, 0);
      chk("rst_credit",   credit_o, 0);
      chk("rst_dispense", dispense_o, 0);
      chk("rst_change",   change_o, 0);
      chk("rst_reject",   coin_reject_o, 0);
      chk("rst_short",    short_o, 0);
      rst = 1'b0;
      tick();

      // Buttons ignored in IDLE
      buy_i = 1; withdraw_i = 1; price_i = 8'd0;
      tick();
      buy_i = 0; withdraw_i = 0;
      chk("idle_btn_state", state_o, 0);
      chk("idle_btn_short", short_o, 0);

      // 1: coin 5, buy 3, vend, 2 change pulses
      coin(3'b100);
      chk("t1_credit5", credit_o, 5);
      chk("t1_state1",  state_o, 1);
      buy_i = 1; price_i = 8'd3;
      tick();
      buy_i = 0;
      chk("t1_vend_state",  state_o, 2);
      chk("t1_vend_credit", credit_o, 2);
`ifdef VEND_AUDIT_EN
      chk("t1_vend_cnt", vend_cnt_o, 1);
      chk("t1_revenue",  revenue_o, 3);
`endif
      ndisp = 0;
      for (int i = 0; i < 20; i++) begin
         if (state_o != 2'd2) break;
         ndisp += int'(dispense_o);
         tick();
      end
      chk("t1_disp_cycles", ndisp, 8);
      chk("t1_refund",      state_o, 3);
      chk("t1_disp_off",    dispense_o, 0);
      ticks(3);
      chk("t1_chg_early",   change_o, 0);
      chk("t1_credit_hold", credit_o, 2);
      tick();
      chk("t1_chg1",        change_o, 1);
      chk("t1_credit1",     credit_o, 1);
      ticks(3);
      chk("t1_chg_gap",     change_o, 0);
      tick();
      chk("t1_chg2",        change_o, 1);
      chk("t1_credit0",     credit_o, 0);
      chk("t1_still_ref",   state_o, 3);
      tick();
      chk("t1_idle",        state_o, 0);
      chk("t1_chg_end",     change_o, 0);

      // 2: coins 1+2+5, buy 10 -> short
      do_reset();
      coin(3'b111);
      chk("t2_credit8", credit_o, 8);
      buy_i = 1; price_i = 8'd10;
      tick();
      buy_i = 0;
      chk("t2_short",        short_o, 1);
      chk("t2_credit_keep",  credit_o, 8);
      chk("t2_state_coin",   state_o, 1);
      tick();
      chk("t2_short_1cyc",   short_o, 0);

      // 3: overflow boundary at 253 / 255
      do_reset();
      for (int i = 0; i < 31; i++) coin(3'b111);
      coin(3'b100);
      chk("t3_credit253", credit_o, 253);
      coin(3'b100);
      chk("t3_reject",       coin_reject_o, 1);
      chk("t3_credit_hold",  credit_o, 253);
      coin(3'b010);
      chk("t3_credit255",    credit_o, 255);
      chk("t3_reject_clear", coin_reject_o, 0);
      coin(3'b001);
      chk("t3_reject_full",  coin_reject_o, 1);
      chk("t3_credit_full",  credit_o, 255);

      // 4: inactivity timeout
      do_reset();
      coin(3'b010);
      chk("t4_credit2", credit_o, 2);
      ticks(99);
      chk("t4_state_99",  state_o, 1);
      tick();
      chk("t4_state_100", state_o, 3);
      drain(nchg, ndisp, ok);
      chk("t4_drain_ok", ok, 1);
      chk("t4_changes",  nchg, 2);
      chk("t4_credit0",  credit_o, 0);

      // 5: buy+withdraw together -> withdraw wins
      do_reset();
      coin(3'b100);
      buy_i = 1; withdraw_i = 1; price_i = 8'd3;
      tick();
      buy_i = 0; withdraw_i = 0;
      chk("t5_refund",    state_o, 3);
      chk("t5_credit5",   credit_o, 5);
      drain(nchg, ndisp, ok);
      chk("t5_drain_ok",  ok, 1);
      chk("t5_changes",   nchg, 5);
      chk("t5_no_disp",   ndisp, 0);

      // 6: coin rejected in VEND, async reset in VEND cycle 3
      do_reset();
      coin(3'b100);
      buy_i = 1; price_i = 8'd3;
      tick();
      buy_i = 0;
      coin(3'b001);
      chk("t6_vend_reject", coin_reject_o, 1);
      chk("t6_vend_credit", credit_o, 2);
      tick();
      chk("t6_vend3_state", state_o, 2);
      chk("t6_vend3_disp",  dispense_o, 1);
`ifdef VEND_AUDIT_EN
      chk("t6_cnt_before",  vend_cnt_o, 1);
`endif
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_disp",   dispense_o, 0);
      chk("t6_rst_credit", credit_o, 0);
      chk("t6_rst_state",  state_o, 0);
`ifdef VEND_AUDIT_EN
      chk("t6_rst_cnt",    vend_cnt_o, 0);
`endif
      tick();
      rst = 1'b0;
      ticks(2);
      chk("t6_post_state", state_o, 0);
      chk("t6_post_chg",   change_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
